echo_sim: RTL and testbench
===========================

// Module: echo_sim
// PURPOSE
//   Ultrasonic ranging-module emulator: the responder end of the trig/echo link driven by sensor_core.
//   Qualifies a trig pulse, waits a fixed burst delay, then drives echo high for a programmed number of us.
//   Used as the on-chip loopback target for sensor_core and as the DUT model for sensor benches.
//   Time base is the shared 1 us strobe pluse_us, one clk_sys cycle wide.
// PARAMETERS
//   TRIG_MIN_US  10     minimum trig high width, in us, for the pulse to be accepted
//   DLY_US       250    us from trig fall to echo rise
//   ECHO_MAX_US  38000  echo width used for "no object": cfg_echo_us==0 or cfg_echo_us>ECHO_MAX_US
//   GUARD_US     10000  dead time, in us, after echo fall; trig is ignored during this time
//   CW           16     width of the us counters and of cfg_echo_us
// PORTS
//   clk_sys      in   1   system clock
//   rst_n        in   1   synchronous reset, active low
//   pluse_us     in   1   1 us tick, one clk_sys cycle wide
//   trig         in   1   asynchronous trig from the initiator
//   cfg_echo_us  in   CW  echo width, in us; sampled on an accepted trig fall
//   echo         out  1   echo pulse to the initiator, registered
//   busy         out  1   high in every state except IDLE and TRIG_HI
//   trig_ign     out  1   1-cycle pulse: a trig rise was ignored, or a trig pulse was too short
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): state=IDLE; echo=0, busy=0, trig_ign=0; counters=0; sync FFs=0.
//   trig input path: 2-FF synchronizer, then a 3rd FF for edge detect. All edges below use the synced trig.
//   All us counters increment only on cycles where pluse_us=1. The counter width is CW; counters saturate and never wrap.
//   IDLE
//     On a trig rise: clear tcnt and go to TRIG_HI.
//   TRIG_HI
//     tcnt increments on pluse_us.
//     On a trig fall with tcnt>=TRIG_MIN_US: latch W and go to DELAY.
//       W = cfg_echo_us when 0<cfg_echo_us<=ECHO_MAX_US; otherwise W = ECHO_MAX_US.
//     On a trig fall with tcnt<TRIG_MIN_US: pulse trig_ign and return to IDLE.
//     If trig stays high, tcnt saturates and the state stays TRIG_HI.
//   DELAY
//     Count DLY_US ticks.
//     On the clk edge that consumes the DLY_US-th tick: state=ECHO and echo goes 1 in the same cycle.
//   ECHO
//     echo=1. Count W ticks.
//     On the edge consuming the W-th tick: echo goes 0 and state=GUARD.
//     The echo high time is therefore W us, within +-1 us of tick phase.
//   GUARD
//     Count GUARD_US ticks, then go to IDLE.
//     If trig is high on entry to IDLE, no rise is seen; the initiator must drop trig and raise it again.
//   Any trig rise seen in DELAY, ECHO or GUARD: pulse trig_ign for 1 cycle; the state is unaffected.
//   Simultaneous trig fall and pluse_us in TRIG_HI: the tick counts first, then the width is compared.
//   cfg_echo_us changes after the latch point do not affect the pulse in flight.
//   Reset asserted mid-pulse: echo drops at the next clk edge and the block returns to IDLE.
//   GUARD_US=0 is legal: GUARD lasts exactly 1 cycle.
//   Latency, trig fall (pin) to echo rise: 2-3 clk sync cycles + DLY_US us.
// TESTING
//   1. Accepted pulse:
//      cfg_echo_us=580; trig high 12 us.
//      -> echo rises 250 us (+-1) after trig fall; echo high 580 us (+-1); busy=1 until the end of GUARD; trig_ign stays 0.
//   2. Short pulse:
//      trig high 5 us.
//      -> exactly one trig_ign pulse; echo stays 0; busy stays 0; state returns to IDLE.
//   3. No object:
//      cfg_echo_us=0, then cfg_echo_us=40000.
//      -> echo width is 38000 us (+-1) in both cases.
//   4. Retrigger:
//      a second 12 us trig during ECHO, and another during GUARD.
//      -> one trig_ign pulse per rise; echo width unchanged; the next trig after GUARD is accepted.
//   5. Reset mid-echo:
//      rst_n=0 for 1 cycle, 100 us into ECHO.
//      -> echo=0 and busy=0 at the next edge; a fresh 12 us trig then yields a normal echo.
//   6. Loopback:
//      sensor_core drives trig; echo_sim drives echo through echo_handle; cfg_echo_us=1160.
//      -> sensor_core measures 1160 us; no error flag.

Source files
------------

// File: rtl/echo_sim.sv
// Ultrasonic ranging responder: qualifies a trig pulse, waits a fixed burst delay,
// then drives echo high for a programmed number of microseconds.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for a synced trig rise
//   ST_TRIG_HI | trig high, measuring its width in us ticks
//   ST_DELAY   | burst delay between trig fall and echo rise
//   ST_ECHO    | echo driven high for the latched width
//   ST_GUARD   | dead time after echo fall, trig rises are ignored
module echo_sim #(
   parameter int TRIG_MIN_US = 10,
   parameter int DLY_US      = 250,
   parameter int ECHO_MAX_US = 38000,
   parameter int GUARD_US    = 10000,
   parameter int CW          = 16
) (
   input  logic          clk_sys,
   input  logic          rst_n,
   input  logic          pluse_us,
   input  logic          trig,
   input  logic [CW-1:0] cfg_echo_us,
   output logic          echo,
   output logic          busy,
   output logic          trig_ign
);

   localparam logic [CW-1:0] TRIG_MIN_C = CW'(TRIG_MIN_US);
   localparam logic [CW-1:0] DLY_C      = CW'(DLY_US);
   localparam logic [CW-1:0] ECHO_MAX_C = CW'(ECHO_MAX_US);
   localparam logic [CW-1:0] GUARD_C    = CW'(GUARD_US);
   localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TRIG_HI = 3'd1,
      ST_DELAY   = 3'd2,
      ST_ECHO    = 3'd3,
      ST_GUARD   = 3'd4
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          trig_s1;
   logic          trig_s2;
   logic          trig_s3;
   logic          trig_rise;
   logic          trig_fall;
   logic [CW-1:0] tcnt;
   logic [CW-1:0] tcnt_nxt;
   logic [CW-1:0] tcnt_inc;
   logic [CW-1:0] dcnt;
   logic [CW-1:0] dcnt_nxt;
   logic [CW-1:0] dcnt_dec;
   logic          dcnt_tc;
   logic [CW-1:0] w_lat;
   logic [CW-1:0] w_nxt;
   logic [CW-1:0] w_sel;
   logic          ign_nxt;

   assign trig_rise = trig_s2 & ~trig_s3;
   assign trig_fall = ~trig_s2 & trig_s3;

   // The trig width counter saturates; the phase down-counter stops at zero.
   assign tcnt_inc = (pluse_us && (tcnt != CNT_MAX)) ? tcnt + CNT_ONE : tcnt;
   assign dcnt_dec = (pluse_us && (dcnt != '0)) ? dcnt - CNT_ONE : dcnt;

   // A zero load (e.g. no guard time) terminates the phase on the next edge.
   assign dcnt_tc  = (dcnt == '0) || (pluse_us && (dcnt == CNT_ONE));

   assign w_sel = ((cfg_echo_us == '0) || (cfg_echo_us > ECHO_MAX_C)) ? ECHO_MAX_C : cfg_echo_us;

   assign busy = (state != ST_IDLE) && (state != ST_TRIG_HI);

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         trig_s1  <= 1'b0;
         trig_s2  <= 1'b0;
         trig_s3  <= 1'b0;
         tcnt     <= '0;
         dcnt     <= '0;
         w_lat    <= '0;
         echo     <= 1'b0;
         trig_ign <= 1'b0;
      end else begin
         state    <= state_nxt;
         trig_s1  <= trig;
         trig_s2  <= trig_s1;
         trig_s3  <= trig_s2;
         tcnt     <= tcnt_nxt;
         dcnt     <= dcnt_nxt;
         w_lat    <= w_nxt;
         echo     <= (state_nxt == ST_ECHO);
         trig_ign <= ign_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tcnt_nxt  = tcnt;
      dcnt_nxt  = dcnt;
      w_nxt     = w_lat;
      ign_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (trig_rise) begin
               tcnt_nxt  = '0;
               state_nxt = ST_TRIG_HI;
            end
         end
         ST_TRIG_HI: begin
            // A tick coincident with the fall still counts toward the width.
            tcnt_nxt = tcnt_inc;
            if (trig_fall) begin
               if (tcnt_inc >= TRIG_MIN_C) begin
                  w_nxt     = w_sel;
                  dcnt_nxt  = DLY_C;
                  state_nxt = ST_DELAY;
               end else begin
                  ign_nxt   = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_DELAY: begin
            ign_nxt = trig_rise;
            if (dcnt_tc) begin
               dcnt_nxt  = w_lat;
               state_nxt = ST_ECHO;
            end else begin
               dcnt_nxt = dcnt_dec;
            end
         end
         ST_ECHO: begin
            ign_nxt = trig_rise;
            if (dcnt_tc) begin
               dcnt_nxt  = GUARD_C;
               state_nxt = ST_GUARD;
            end else begin
               dcnt_nxt = dcnt_dec;
            end
         end
         ST_GUARD: begin
            ign_nxt = trig_rise;
            if (dcnt_tc) begin
               dcnt_nxt  = '0;
               state_nxt = ST_IDLE;
            end else begin
               dcnt_nxt = dcnt_dec;
            end
         end
         default: begin
            dcnt_nxt  = '0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_echo_sim.sv
// Randomized scoreboard bench for echo_sim: stimulus pushes expected echo pulses and
// trig_ign pulses into queues, an independent monitor pops and checks them.
module tb_echo_sim;

   localparam int P    = 4;     // clk_sys cycles per us tick
   localparam int TMIN = 10;
   localparam int DLY  = 25;
   localparam int EMAX = 600;
   localparam int GRD  = 40;

   typedef struct {
      int w;
      int fall;
      int abort_at;
   } echo_exp_t;

   typedef struct {
      int lo;
      int hi;
   } ign_exp_t;

   logic        clk_sys = 1'b0;
   logic        rst_n;
   logic        pluse_us;
   logic        trig;
   logic [15:0] cfg_echo_us;
   logic        echo;
   logic        busy;
   logic        trig_ign;

   int cyc     = 0;
   int n_chk   = 0;
   int n_fail  = 0;

   echo_exp_t echo_q[$];
   ign_exp_t  ign_q[$];

   echo_sim #(
      .TRIG_MIN_US (TMIN),
      .DLY_US      (DLY),
      .ECHO_MAX_US (EMAX),
      .GUARD_US    (GRD),
      .CW          (16)
   ) dut (
      .clk_sys     (clk_sys),
      .rst_n       (rst_n),
      .pluse_us    (pluse_us),
      .trig        (trig),
      .cfg_echo_us (cfg_echo_us),
      .echo        (echo),
      .busy        (busy),
      .trig_ign    (trig_ign)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   initial begin
      pluse_us = 1'b0;
      forever begin
         for (int k = 0; k < P; k++) begin
            @(negedge clk_sys);
            pluse_us = (k == P - 1);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
      end
   endtask

   // Reference rule for the echo width actually produced.
   function automatic int exp_w(input int cfg);
      if (cfg == 0 || cfg > EMAX) return EMAX;
      return cfg;
   endfunction

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk_sys);
   endtask

   task automatic pulse(input int hi_us, output int rise_c, output int fall_c);
      trig   = 1'b1;
      rise_c = cyc;
      repeat (hi_us * P) @(negedge clk_sys);
      trig   = 1'b0;
      fall_c = cyc;
   endtask

   task automatic retrig(input int at);
      int r, f;
      ign_exp_t ie;
      wait_until(at);
      ie.lo = cyc + 2;
      ie.hi = cyc + 5;
      ign_q.push_back(ie);
      pulse(12, r, f);
   endtask

   task automatic short_pulse(input int hi_us);
      int r, f;
      ign_exp_t ie;
      pulse(hi_us, r, f);
      ie.lo = f + 2;
      ie.hi = f + 5;
      ign_q.push_back(ie);
      repeat (20) @(negedge clk_sys);
      chk("short_busy", int'(busy), 0);
      chk("short_echo", int'(echo), 0);
   endtask

   task automatic accepted(input int cfg, input int hi_us, input int n_re, input bit do_rst);
      int r, f, w, rc, t1, t2;
      echo_exp_t ee;
      cfg_echo_us = 16'(cfg);
      w = exp_w(cfg);
      pulse(hi_us, r, f);
      rc          = f + (DLY + 100) * P;
      ee.w        = w;
      ee.fall     = f;
      ee.abort_at = do_rst ? rc + 1 : -1;
      echo_q.push_back(ee);
      repeat (10) @(negedge clk_sys);
      cfg_echo_us = 16'($urandom);
      if (do_rst) begin
         wait_until(rc);
         rst_n = 1'b0;
         @(negedge clk_sys);
         chk("rst_echo", int'(echo), 0);
         chk("rst_busy", int'(busy), 0);
         rst_n = 1'b1;
         repeat (8) @(negedge clk_sys);
         return;
      end
      t1 = f + (DLY + 1) * P + int'($urandom_range(0, w - 1)) * P;
      if (n_re >= 1) retrig(t1);
      t2 = ((t1 + 13 * P > f + (DLY + w + 1) * P) ? t1 + 13 * P : f + (DLY + w + 1) * P)
           + int'($urandom_range(0, GRD / 2)) * P;
      if (n_re >= 2 && t2 <= f + (DLY + w + GRD - 2) * P) retrig(t2);
      wait_until(f + (DLY + w + GRD + 2) * P + 8);
      chk("idle_busy", int'(busy), 0);
      chk("idle_echo", int'(echo), 0);
   endtask

   // Monitor: checks every echo pulse and every trig_ign pulse against the queues.
   initial begin
      logic echo_d;
      int   rise_c;
      echo_exp_t ee;
      ign_exp_t  ie;
      echo_d = 1'b0;
      rise_c = 0;
      forever begin
         @(negedge clk_sys);
         if (echo && !echo_d) begin
            rise_c = cyc;
            if (echo_q.size() == 0) begin
               chk("echo_unexpected", 1, 0);
            end else begin
               chk_rng("echo_delay", cyc - echo_q[0].fall, (DLY - 1) * P + 4, DLY * P + 3);
               chk("echo_busy", int'(busy), 1);
            end
         end
         if (!echo && echo_d) begin
            if (echo_q.size() == 0) begin
               chk("echo_fall_unexpected", 1, 0);
            end else begin
               ee = echo_q.pop_front();
               if (ee.abort_at >= 0)
                  chk("echo_abort_cycle", cyc, ee.abort_at);
               else
                  chk_rng("echo_width", cyc - rise_c, ee.w * P - P + 1, ee.w * P + P - 1);
            end
         end
         echo_d = echo;
         if (trig_ign) begin
            if (ign_q.size() == 0) begin
               chk("ign_unexpected", 1, 0);
            end else begin
               ie = ign_q.pop_front();
               chk_rng("ign_cycle", cyc, ie.lo, ie.hi);
            end
         end
      end
   end

   initial begin
      repeat (95000) @(posedge clk_sys);
      $display("FAIL watchdog: cycle budget exhausted at %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int kind, cfg;
      trig        = 1'b0;
      rst_n       = 1'b0;
      cfg_echo_us = '0;
      repeat (3) @(negedge clk_sys);
      chk("reset_echo", int'(echo), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_ign", int'(trig_ign), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_sys);

      accepted(580, 12, 0, 0);
      short_pulse(5);
      accepted(50, TMIN, 0, 0);
      short_pulse(TMIN - 1);
      accepted(0, 12, 0, 0);
      accepted(40000, 12, 0, 0);
      accepted(EMAX, 12, 0, 0);
      accepted(EMAX + 1, 12, 0, 0);
      accepted(1, 12, 0, 0);
      accepted(120, 12, 2, 0);
      accepted(200, 12, 0, 1);
      accepted(150, 12, 0, 0);

      for (int i = 0; i < 20; i++) begin
         kind = int'($urandom_range(0, 3));
         if (kind == 0) begin
            short_pulse(int'($urandom_range(1, TMIN - 1)));
         end else begin
            case ($urandom_range(0, 9))
               0:       cfg = 0;
               1:       cfg = EMAX;
               2:       cfg = int'($urandom_range(EMAX + 1, 65535));
               default: cfg = int'($urandom_range(1, 150));
            endcase
            accepted(cfg, int'($urandom_range(TMIN, 20)), int'($urandom_range(0, 2)), 1'b0);
         end
      end

      repeat (20) @(negedge clk_sys);
      chk("echo_q_drained", echo_q.size(), 0);
      chk("ign_q_drained", ign_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
